// File: rtl/gray_counter_param_if.sv
// Control and count bus of the parametrised Gray counter; the counter side is the slave.
interface gray_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  bin_count, gray_count, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bin_count, gray_count, tc, wrap
    );
endinterface

// File: rtl/gray_counter_param.sv
// Up/down binary counter with registered Gray mirror, parallel load, optional saturation
// and a one-cycle wrap pulse; gray_count is registered so it can cross clock domains cleanly.
module gray_counter_param #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    gray_counter_param_if.slave   bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (bin_q != ALL_ONES) begin
                    bin_d = bin_q + ONE;
                end else if (SATURATE == 0) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    bin_d = bin_q - ONE;
                end else if (SATURATE == 0) begin
                    bin_d  = ALL_ONES;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Gray code is derived from the next binary value so both register on the same edge.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_d[gi] = bin_d[gi] ^ bin_d[gi+1];
        end
    endgenerate
    assign gray_d[WIDTH-1] = bin_d[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin_count  = bin_q;
    assign bus.gray_count = gray_q;
    assign bus.wrap       = wrap_q;
    assign bus.tc         = bus.up_dn ? (bin_q == ALL_ONES) : (bin_q == '0);
endmodule
